pipelined_mips_cpu: RTL and testbench

PIPELINED_MIPS_CPU -- requirements
Module: pipelined_mips_cpu

---
 rtl/pipelined_mips_cpu_pkg.sv | 116 +++++++++++
 rtl/pipelined_mips_cpu_hazard_unit.sv | 56 +++++
 rtl/pipelined_mips_cpu.sv | 182 ++++++++++++++++++
 tb/tb_pipelined_mips_cpu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_mips_cpu_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: opcode/funct constants,
// ALU control and forwarding-select encodings, pipeline register layouts,
// and the instruction decoder / ALU helper functions.
package pipelined_mips_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctl_e;

  // Execute operand source: register file value, W-stage result, M-stage ALU result
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_to_reg;
    logic     mem_write;
    logic     alu_src;
    logic     reg_dst;
    logic     branch;
    logic     jump;
    alu_ctl_e alu_ctl;
  } ctrl_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    alu_ctl_e    alu_ctl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } de_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic [4:0]  wreg;
  } em_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] rdata;
    logic [31:0] alu_out;
    logic [4:0]  wreg;
  } mw_t;

  // Unsupported encodings (including unknown R-type functs) decode to all-zero
  // control, so they flow through as no-ops.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  c.alu_ctl = ALU_ADD;
          FN_SUB:  c.alu_ctl = ALU_SUB;
          FN_AND:  c.alu_ctl = ALU_AND;
          FN_OR:   c.alu_ctl = ALU_OR;
          FN_SLT:  c.alu_ctl = ALU_SLT;
          default: c = '0;
        endcase
      end
      OP_LW:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; end
      OP_SW:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      OP_BEQ:  c.branch = 1'b1;
      OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      OP_J:    c.jump = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input alu_ctl_e ctl);
    case (ctl)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_mips_cpu_hazard_unit.sv
// Hazard unit: combinational forwarding selects for Execute and for the
// Decode-stage branch comparator, plus the single stall signal (lw-use and
// branch-operand hazards). stall holds PC and F/D and flushes D/E.
//   in : D/E/M/W register specifiers and write/load flags
//   out: fwd_a_e, fwd_b_e (fwd_sel_e), fwd_a_d, fwd_b_d, stall
module hazard_unit
  import pipelined_mips_cpu_pkg::*;
(
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       branch_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic       reg_write_e,
  input  logic       mem_to_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_m,
  input  logic       mem_to_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_w,
  output fwd_sel_e   fwd_a_e,
  output fwd_sel_e   fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic       stall
);

  logic lw_stall, br_stall;

  // M has priority over W: it holds the younger value.
  function automatic fwd_sel_e ex_fwd(input logic [4:0] src, input logic [4:0] wm,
                                      input logic rwm, input logic [4:0] ww,
                                      input logic rww);
    if (src != 5'd0 && rwm && src == wm) return FWD_MEM;
    if (src != 5'd0 && rww && src == ww) return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_a_e = ex_fwd(rs_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);
  assign fwd_b_e = ex_fwd(rt_e, write_reg_m, reg_write_m, write_reg_w, reg_write_w);

  // Older W-stage values reach Decode through the register file bypass.
  assign fwd_a_d = (rs_d != 5'd0) && reg_write_m && (rs_d == write_reg_m);
  assign fwd_b_d = (rt_d != 5'd0) && reg_write_m && (rt_d == write_reg_m);

  assign lw_stall = mem_to_reg_e && (write_reg_e == rs_d || write_reg_e == rt_d);

  // ALUOutM of an M-stage lw is an address, not data, so it cannot feed beq.
  assign br_stall = branch_d &&
                    ((reg_write_e  && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                     (mem_to_reg_m && (write_reg_m == rs_d || write_reg_m == rt_d)));

  assign stall = lw_stall | br_stall;

endmodule

// File: rtl/pipelined_mips_cpu.sv
// Classic 5-stage (F/D/E/M/W) MIPS subset pipeline with forwarding, lw-use
// and branch stalls, and Decode-stage beq/j resolution (one squashed slot).
//   CLK, RST (async, active-low)
//   IM_RD      : instruction word at PCF (combinational memory)
//   DM_RD      : data word at ALUOutM (combinational memory)
//   MemWriteM, ALUOutM, WriteDataM : M-stage data memory request
//   PCF, InstrD : fetch PC and decode-stage instruction
module pipelined_mips_cpu
  import pipelined_mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IM_RD,
  input  logic [31:0] DM_RD,
  output logic        MemWriteM,
  output logic [31:0] ALUOutM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCF,
  output logic [31:0] InstrD
);

  logic [31:0] rf [32];
  logic [31:0] pc_plus4_f, pc_plus4_d, pc_next;
  ctrl_t       ctrl_d;
  logic [4:0]  rs_d, rt_d;
  logic [31:0] imm_d, rd1_d, rd2_d, cmp_a_d, cmp_b_d, br_target_d, j_target_d;
  logic        redirect_d, stall, fwd_a_d, fwd_b_d;
  fwd_sel_e    fwd_a_e, fwd_b_e;
  de_t         de;
  em_t         em;
  mw_t         mw;
  logic [31:0] src_a_e, src_b_e, wdata_e, alu_e, result_w;
  logic [4:0]  wreg_e;

  // ---------------- Fetch ----------------
  assign pc_plus4_f = PCF + 32'd4;
  assign pc_next    = redirect_d ? (ctrl_d.jump ? j_target_d : br_target_d) : pc_plus4_f;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        PCF <= RESET_PC;
    else if (!stall) PCF <= pc_next;
  end

  // F/D: stall holds; a redirect squashes the slot behind beq/j.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      InstrD     <= '0;
      pc_plus4_d <= '0;
    end else if (!stall) begin
      if (redirect_d) begin
        InstrD     <= '0;
        pc_plus4_d <= '0;
      end else begin
        InstrD     <= IM_RD;
        pc_plus4_d <= pc_plus4_f;
      end
    end
  end

  // ---------------- Decode ----------------
  assign ctrl_d = decode(InstrD[31:26], InstrD[5:0]);
  assign rs_d   = InstrD[25:21];
  assign rt_d   = InstrD[20:16];
  assign imm_d  = {{16{InstrD[15]}}, InstrD[15:0]};

  // Write-through bypass so D sees the value W writes this cycle.
  assign rd1_d = (rs_d == 5'd0) ? 32'd0 :
                 (mw.reg_write && mw.wreg == rs_d) ? result_w : rf[rs_d];
  assign rd2_d = (rt_d == 5'd0) ? 32'd0 :
                 (mw.reg_write && mw.wreg == rt_d) ? result_w : rf[rt_d];

  assign cmp_a_d     = fwd_a_d ? em.alu_out : rd1_d;
  assign cmp_b_d     = fwd_b_d ? em.alu_out : rd2_d;
  assign br_target_d = pc_plus4_d + {imm_d[29:0], 2'b00};
  assign j_target_d  = {pc_plus4_d[31:28], InstrD[25:0], 2'b00};

  // A stalled branch does not redirect; it is re-evaluated next cycle.
  assign redirect_d = ((ctrl_d.branch && cmp_a_d == cmp_b_d) || ctrl_d.jump) && !stall;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (mw.reg_write && mw.wreg != 5'd0) begin
      rf[mw.wreg] <= result_w;
    end
  end

  // D/E: a stall injects an all-zero bubble.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST || stall) begin
      de <= '0;
    end else begin
      de.reg_write  <= ctrl_d.reg_write;
      de.mem_to_reg <= ctrl_d.mem_to_reg;
      de.mem_write  <= ctrl_d.mem_write;
      de.alu_src    <= ctrl_d.alu_src;
      de.reg_dst    <= ctrl_d.reg_dst;
      de.alu_ctl    <= ctrl_d.alu_ctl;
      de.rd1        <= rd1_d;
      de.rd2        <= rd2_d;
      de.imm        <= imm_d;
      de.rs         <= rs_d;
      de.rt         <= rt_d;
      de.rd         <= InstrD[15:11];
    end
  end

  // ---------------- Execute ----------------
  always_comb begin
    case (fwd_a_e)
      FWD_MEM: src_a_e = em.alu_out;
      FWD_WB:  src_a_e = result_w;
      default: src_a_e = de.rd1;
    endcase
    case (fwd_b_e)
      FWD_MEM: wdata_e = em.alu_out;
      FWD_WB:  wdata_e = result_w;
      default: wdata_e = de.rd2;
    endcase
  end

  assign src_b_e = de.alu_src ? de.imm : wdata_e;
  assign alu_e   = alu(src_a_e, src_b_e, de.alu_ctl);
  assign wreg_e  = de.reg_dst ? de.rd : de.rt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      em <= '0;
    end else begin
      em.reg_write  <= de.reg_write;
      em.mem_to_reg <= de.mem_to_reg;
      em.mem_write  <= de.mem_write;
      em.alu_out    <= alu_e;
      em.wdata      <= wdata_e;
      em.wreg       <= wreg_e;
    end
  end

  // ---------------- Memory ----------------
  assign MemWriteM  = em.mem_write;
  assign ALUOutM    = em.alu_out;
  assign WriteDataM = em.wdata;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mw <= '0;
    end else begin
      mw.reg_write  <= em.reg_write;
      mw.mem_to_reg <= em.mem_to_reg;
      mw.rdata      <= DM_RD;
      mw.alu_out    <= em.alu_out;
      mw.wreg       <= em.wreg;
    end
  end

  // ---------------- Writeback ----------------
  assign result_w = mw.mem_to_reg ? mw.rdata : mw.alu_out;

  hazard_unit u_hazard (
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .branch_d     (ctrl_d.branch),
    .rs_e         (de.rs),
    .rt_e         (de.rt),
    .write_reg_e  (wreg_e),
    .reg_write_e  (de.reg_write),
    .mem_to_reg_e (de.mem_to_reg),
    .write_reg_m  (em.wreg),
    .reg_write_m  (em.reg_write),
    .mem_to_reg_m (em.mem_to_reg),
    .write_reg_w  (mw.wreg),
    .reg_write_w  (mw.reg_write),
    .fwd_a_e      (fwd_a_e),
    .fwd_b_e      (fwd_b_e),
    .fwd_a_d      (fwd_a_d),
    .fwd_b_d      (fwd_b_d),
    .stall        (stall)
  );

endmodule

// File: tb/tb_pipelined_mips_cpu.sv
// Bench for pipelined_mips_cpu: small programs run from a bench-side
// instruction/data memory; per-program expectation tables (cycle, signal,
// value) are pushed into a scoreboard at reset release and popped/compared
// as the pipeline reaches each cycle. Cycle k = k-th rising edge after release.
module tb_pipelined_mips_cpu;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] IM_RD, DM_RD;
  logic        MemWriteM;
  logic [31:0] ALUOutM, WriteDataM, PCF, InstrD;

  pipelined_mips_cpu #(.RESET_PC(32'h0000_0000)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IM_RD      (IM_RD),
    .DM_RD      (DM_RD),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .PCF        (PCF),
    .InstrD     (InstrD)
  );

  always #5 CLK = ~CLK;

  logic [31:0] imem [128];
  logic [31:0] dmem [64];
  assign IM_RD = imem[PCF[8:2]];
  assign DM_RD = dmem[ALUOutM[7:2]];

  // Data memory: word 1 preloads to 2 while reset is held.
  always @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 64; i++) dmem[i] <= (i == 1) ? 32'd2 : 32'd0;
    end else if (MemWriteM) begin
      dmem[ALUOutM[7:2]] <= WriteDataM;
    end
  end

  typedef enum logic [2:0] {S_PCF, S_INSTRD, S_ALUOUT, S_MEMWR, S_WDATA} sig_e;
  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int c, input sig_e s, input logic [31:0] e);
    vec_t v;
    v.cyc = c; v.sig = s; v.exp = e;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_PCF:    return PCF;
      S_INSTRD: return InstrD;
      S_ALUOUT: return ALUOutM;
      S_MEMWR:  return {31'd0, MemWriteM};
      default:  return WriteDataM;
    endcase
  endfunction

  task automatic drain();
    vec_t v;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      v = sb.pop_front();
      check($sformatf("%s@cyc%0d", v.sig.name(), v.cyc), actual(v.sig), v.exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 128; i++) imem[i] = 32'd0;
    tbl.delete();
  endtask

  // Reset, release, push the table into the scoreboard, step ncyc cycles.
  task automatic run(input int ncyc);
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    cyc = 0;
    foreach (tbl[i]) sb.push_back(tbl[i]);
    drain();
    for (int k = 0; k < ncyc; k++) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      drain();
    end
    while (sb.size() != 0) begin
      vec_t v;
      v = sb.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL pending %s@cyc%0d: not reached within %0d cycles", v.sig.name(), v.cyc, ncyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------- Program A: back-to-back forwarding, ALU ops, $0 ----------
    clear_prog();
    imem[0]  = enc_i(6'h08, 5'd1, 5'd0, 16'd5);        // addi $1,$0,5
    imem[1]  = enc_r(6'h20, 5'd2, 5'd1, 5'd1);         // add  $2,$1,$1
    imem[2]  = enc_r(6'h22, 5'd3, 5'd2, 5'd1);         // sub  $3,$2,$1
    imem[3]  = enc_r(6'h25, 5'd4, 5'd2, 5'd1);         // or   $4,$2,$1
    imem[4]  = enc_r(6'h24, 5'd5, 5'd4, 5'd2);         // and  $5,$4,$2
    imem[5]  = enc_i(6'h08, 5'd7, 5'd0, 16'hFFFD);     // addi $7,$0,-3
    imem[6]  = enc_r(6'h2A, 5'd6, 5'd7, 5'd1);         // slt  $6,$7,$1
    imem[7]  = enc_r(6'h2A, 5'd8, 5'd1, 5'd7);         // slt  $8,$1,$7
    imem[8]  = enc_r(6'h20, 5'd0, 5'd1, 5'd1);         // add  $0,$1,$1
    imem[9]  = enc_r(6'h20, 5'd9, 5'd0, 5'd0);         // add  $9,$0,$0
    imem[10] = enc_r(6'h22, 5'd10, 5'd1, 5'd7);        // sub  $10,$1,$7
    imem[11] = enc_r(6'h20, 5'd11, 5'd0, 5'd1);        // add  $11,$0,$1

    // Hand-written reset sequence: outputs stay clear while RST is low.
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_PCF", PCF, 32'h0);
    check("reset_InstrD", InstrD, 32'h0);
    check("reset_MemWriteM", {31'd0, MemWriteM}, 32'h0);
    check("reset_ALUOutM", ALUOutM, 32'h0);
    check("reset_WriteDataM", WriteDataM, 32'h0);

    add(0, S_PCF, 32'h0);
    add(1, S_PCF, 32'h4);
    add(1, S_INSTRD, imem[0]);
    add(2, S_PCF, 32'h8);
    add(3, S_PCF, 32'hC);
    add(3, S_ALUOUT, 32'd5);
    add(3, S_MEMWR, 32'd0);
    add(4, S_ALUOUT, 32'd10);
    add(4, S_PCF, 32'h10);
    add(5, S_ALUOUT, 32'd5);
    add(6, S_ALUOUT, 32'd15);
    add(7, S_ALUOUT, 32'd10);
    add(8, S_ALUOUT, 32'hFFFF_FFFD);
    add(9, S_ALUOUT, 32'd1);
    add(10, S_ALUOUT, 32'd0);
    add(11, S_ALUOUT, 32'd10);
    add(12, S_ALUOUT, 32'd0);
    add(13, S_ALUOUT, 32'd8);
    add(14, S_ALUOUT, 32'd5);
    run(16);

    // ---------- Program B: lw-use stalls, stores, load of stored data ----------
    clear_prog();
    imem[0] = enc_i(6'h23, 5'd3, 5'd0, 16'd4);         // lw   $3,4($0)   (=2)
    imem[1] = enc_r(6'h20, 5'd4, 5'd3, 5'd3);          // add  $4,$3,$3
    imem[2] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);         // addi $1,$0,5
    imem[3] = enc_i(6'h2B, 5'd1, 5'd0, 16'd8);         // sw   $1,8($0)
    imem[4] = enc_i(6'h23, 5'd5, 5'd0, 16'd8);         // lw   $5,8($0)
    imem[5] = enc_r(6'h20, 5'd6, 5'd5, 5'd1);          // add  $6,$5,$1
    imem[6] = enc_i(6'h2B, 5'd6, 5'd0, 16'd12);        // sw   $6,12($0)
    add(2, S_PCF, 32'h8);
    add(3, S_PCF, 32'h8);
    add(3, S_ALUOUT, 32'd4);
    add(3, S_MEMWR, 32'd0);
    add(4, S_PCF, 32'hC);
    add(4, S_ALUOUT, 32'd0);
    add(4, S_MEMWR, 32'd0);
    add(5, S_ALUOUT, 32'd4);
    add(6, S_ALUOUT, 32'd5);
    add(7, S_MEMWR, 32'd1);
    add(7, S_ALUOUT, 32'd8);
    add(7, S_WDATA, 32'd5);
    add(8, S_ALUOUT, 32'd8);
    add(8, S_MEMWR, 32'd0);
    add(9, S_ALUOUT, 32'd0);
    add(10, S_ALUOUT, 32'd10);
    add(11, S_MEMWR, 32'd1);
    add(11, S_ALUOUT, 32'd12);
    add(11, S_WDATA, 32'd10);
    run(13);

    // ---------- Program C: branch stall, not-taken/taken beq, j ----------
    clear_prog();
    imem[0]  = enc_i(6'h08, 5'd1, 5'd0, 16'd1);        // addi $1,$0,1
    imem[1]  = enc_i(6'h08, 5'd2, 5'd0, 16'd2);        // addi $2,$0,2
    imem[2]  = enc_i(6'h04, 5'd2, 5'd1, 16'd5);        // beq  $1,$2,+5 (not taken)
    imem[3]  = enc_i(6'h08, 5'd3, 5'd0, 16'd3);        // addi $3,$0,3
    imem[4]  = enc_i(6'h04, 5'd0, 5'd0, 16'd3);        // beq  $0,$0,+3 -> 0x20
    imem[5]  = enc_i(6'h08, 5'd4, 5'd0, 16'h44);       // squashed
    imem[8]  = {6'h02, 26'h40};                        // j    0x40 -> 0x100
    imem[9]  = enc_i(6'h08, 5'd5, 5'd0, 16'h55);       // squashed
    imem[64] = enc_i(6'h08, 5'd6, 5'd1, 16'd7);        // addi $6,$1,7
    add(3, S_PCF, 32'hC);
    add(3, S_ALUOUT, 32'd1);
    add(4, S_PCF, 32'hC);
    add(4, S_INSTRD, imem[2]);
    add(4, S_ALUOUT, 32'd2);
    add(5, S_PCF, 32'h10);
    add(5, S_ALUOUT, 32'd0);
    add(5, S_MEMWR, 32'd0);
    add(6, S_PCF, 32'h14);
    add(7, S_PCF, 32'h20);
    add(7, S_INSTRD, 32'h0);
    add(7, S_ALUOUT, 32'd3);
    add(8, S_PCF, 32'h24);
    add(8, S_INSTRD, imem[8]);
    add(9, S_PCF, 32'h100);
    add(9, S_INSTRD, 32'h0);
    add(9, S_ALUOUT, 32'd0);
    add(11, S_ALUOUT, 32'd0);
    add(12, S_ALUOUT, 32'd8);
    run(14);

    // Hand-written: reset acts without waiting for a clock edge.
    @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check("async_reset_PCF", PCF, 32'h0);
    check("async_reset_InstrD", InstrD, 32'h0);
    check("async_reset_ALUOutM", ALUOutM, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
